// File: rtl/data_upload_pkg.sv
// data_upload shared types, constants and CRC helper.
// Optional CRC datapath: define DATA_UPLOAD_CRC_EN.
package data_upload_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_t;

  localparam int          ADDR_W_DEF   = 25;
  localparam logic [7:0]  CMD_READ_DEF = 8'h57;
  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;

  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input logic [7:0]  b
  );
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/data_upload_spi_sync.sv
// SPI pin synchronizer for data_upload.
// 2-FF sync of sck/ss/sdi plus sck and ss edge detect.
module spi_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic ss,
  input  logic sdi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_rise,
  output logic ss_fall,
  output logic sdi_s
);

  logic [2:0] sck_q, sck_d;
  logic [2:0] ss_q, ss_d;
  logic [1:0] sdi_q, sdi_d;

  // shift each pin through its sync chain; bit 2 is the previous value
  always_comb begin
    sck_d = {sck_q[1:0], sck};
    ss_d  = {ss_q[1:0], ss};
    sdi_d = {sdi_q[0], sdi};
  end

  // sync registers; ss resets inactive so no edge is seen at reset exit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q <= 3'b000;
      ss_q  <= 3'b111;
      sdi_q <= 2'b00;
    end else begin
      sck_q <= sck_d;
      ss_q  <= ss_d;
      sdi_q <= sdi_d;
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign sdi_s    = sdi_q[1];

endmodule

// File: rtl/data_upload.sv
// data_upload: SPI slave that streams memory bytes to the IO controller.
// Optional CRC-16/CCITT of sent bytes: define DATA_UPLOAD_CRC_EN.
module data_upload
  import data_upload_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter logic [7:0] CMD_READ = CMD_READ_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              uploading,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              underrun,
  output logic [15:0]       crc
);

  logic sck_rise, sck_fall, ss_rise, ss_fall, sdi_s;

  spi_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sck      (sck),
    .ss       (ss),
    .sdi      (sdi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall),
    .sdi_s    (sdi_s)
  );

  state_t            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] sh_q, sh_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic              discard_q, discard_d;
  logic              stale_q, stale_d;
  logic              pend_q, pend_d;
  logic              ld_q, ld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              underrun_q, underrun_d;
`ifdef DATA_UPLOAD_CRC_EN
  logic [15:0]       crc_q, crc_d;
`endif

  logic              issue;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic              ack_fill;
  logic              bus_free;

  // protocol FSM, prefetch buffer and single-outstanding read control
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    discard_d   = discard_q;
    stale_d     = stale_q;
    pend_d      = pend_q;
    ld_d        = ld_q;
    rd_addr_d   = rd_addr_q;
    mem_rd_d    = mem_rd_q & ~mem_ack;
    mem_addr_d  = mem_addr_q;
    underrun_d  = underrun_q;
`ifdef DATA_UPLOAD_CRC_EN
    crc_d       = crc_q;
`endif
    issue       = 1'b0;
    iss_addr    = rd_addr_q;
    nxt_addr    = rd_addr_q;
    ack_fill    = mem_ack & ~stale_q & ~discard_q;
    bus_free    = ~mem_rd_q | mem_ack;

    if (mem_ack) begin
      if (stale_q) begin
        stale_d = 1'b0;
      end else if (discard_q) begin
        discard_d = 1'b0;
        issue     = 1'b1;
      end else begin
        buf_d       = mem_data;
        buf_valid_d = 1'b1;
      end
    end

    if (ss_rise) begin
      state_d     = S_IDLE;
      issue       = 1'b0;
      pend_d      = 1'b0;
      buf_valid_d = 1'b0;
      discard_d   = 1'b0;
      ld_d        = 1'b0;
      stale_d     = mem_rd_q & ~mem_ack;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ss_fall) begin
            state_d     = S_CMD;
            bit_cnt_d   = '0;
            sh_d        = '0;
            underrun_d  = 1'b0;
            discard_d   = 1'b0;
            buf_valid_d = 1'b0;
            pend_d      = 1'b0;
            ld_d        = 1'b0;
`ifdef DATA_UPLOAD_CRC_EN
            crc_d       = CRC_INIT;
`endif
          end
        end
        S_CMD: begin
          if (sck_rise) begin
            sh_d      = {sh_q[ADDR_W-2:0], sdi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = (sh_d[7:0] == CMD_READ) ? S_ADDR : S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (sck_rise) begin
            sh_d      = {sh_q[ADDR_W-2:0], sdi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_d = '0;
              issue     = 1'b1;
              iss_addr  = sh_d;
              state_d   = S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              ld_d      = 1'b1;
              state_d   = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              ld_d      = 1'b1;
            end
          end else if (sck_fall) begin
            if (ld_q) begin
              ld_d = 1'b0;
              if (buf_valid_q | ack_fill) begin
                tx_d        = buf_valid_q ? buf_q : mem_data;
                buf_valid_d = 1'b0;
                issue       = 1'b1;
                iss_addr    = rd_addr_q;
              end else begin
                tx_d       = 8'hFF;
                underrun_d = 1'b1;
                discard_d  = 1'b1;
              end
`ifdef DATA_UPLOAD_CRC_EN
              crc_d = crc16_byte(crc_q, tx_d);
`endif
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        S_IGNORE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (!ss_rise) begin
      if ((issue | pend_q) & bus_free) begin
        nxt_addr   = issue ? iss_addr : rd_addr_q;
        mem_rd_d   = 1'b1;
        mem_addr_d = nxt_addr;
        rd_addr_d  = nxt_addr + ADDR_W'(1);
        pend_d     = 1'b0;
      end else if (issue) begin
        pend_d    = 1'b1;
        rd_addr_d = iss_addr;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      tx_q        <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      discard_q   <= 1'b0;
      stale_q     <= 1'b0;
      pend_q      <= 1'b0;
      ld_q        <= 1'b0;
      rd_addr_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      underrun_q  <= 1'b0;
`ifdef DATA_UPLOAD_CRC_EN
      crc_q       <= CRC_INIT;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      discard_q   <= discard_d;
      stale_q     <= stale_d;
      pend_q      <= pend_d;
      ld_q        <= ld_d;
      rd_addr_q   <= rd_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      underrun_q  <= underrun_d;
`ifdef DATA_UPLOAD_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign sdo       = (state_q == S_DATA) & tx_q[7];
  assign sdo_oe    = (state_q == S_DUMMY) | (state_q == S_DATA);
  assign uploading = (state_q == S_ADDR) | sdo_oe;
  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign underrun  = underrun_q;
`ifdef DATA_UPLOAD_CRC_EN
  assign crc       = crc_q;
`else
  assign crc       = 16'h0000;
`endif

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload.
// Memory model answers with addr[7:0]; one address can be slowed.
module tb_data_upload;
  import data_upload_pkg::*;

  localparam int AW   = 25;
  localparam int HALF = 50;
`ifdef DATA_UPLOAD_CRC_EN
  localparam logic [15:0] CRC_RST = 16'hFFFF;
  localparam logic [15:0] CRC_EXP = 16'h29B1;
`else
  localparam logic [15:0] CRC_RST = 16'h0000;
  localparam logic [15:0] CRC_EXP = 16'h0000;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sck;
  logic          ss;
  logic          sdi;
  logic          sdo;
  logic          sdo_oe;
  logic          uploading;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_data = 8'h00;
  logic          underrun;
  logic [15:0]   crc;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] slow_addr;
  int            slow_dly;
  logic [AW-1:0] log_a [64];
  int            log_n  = 0;
  int            rd_cnt = 0;
  logic [7:0]    rxb [16];
  int            base;
  int            rd_base;

  always #5 clk = ~clk;

  data_upload dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sck       (sck),
    .ss        (ss),
    .sdi       (sdi),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .uploading (uploading),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .underrun  (underrun),
    .crc       (crc)
  );

  initial begin
    logic busy;
    int   cnt;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (!mem_rd) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          log_a[log_n[5:0]] = mem_addr;
          log_n++;
        end
        cnt++;
        if (cnt >= ((mem_addr == slow_addr) ? slow_dly : 3)) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr[7:0];
          busy     = 1'b0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [AW-1:0] req(input int i);
    return log_a[i[5:0]];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic spi_byte(
    input  logic [7:0] tx,
    output logic [7:0] rx,
    input  bit         last
  );
    for (int i = 7; i >= 0; i--) begin
      sdi = tx[i];
      #HALF;
      sck   = 1'b1;
      rx[i] = sdo;
      #HALF;
      if (!(last && i == 0)) sck = 1'b0;
    end
  endtask

  task automatic start_tx(input logic [31:0] a);
    logic [7:0] d;
    ss = 1'b0;
    #HALF;
    spi_byte(8'h57, d, 1'b0);
    for (int k = 3; k >= 0; k--) spi_byte(a[8*k +: 8], d, 1'b0);
    spi_byte(8'h00, d, 1'b0);
  endtask

  task automatic get_bytes(input int n, input bit last);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, d, last && (k == n - 1));
      rxb[k] = d;
    end
  endtask

  task automatic end_tx;
    #HALF;
    ss = 1'b1;
    tick(3);
    sck = 1'b0;
    tick(20);
  endtask

  initial begin
    logic [7:0] d;
    reset_n   = 1'b0;
    sck       = 1'b0;
    ss        = 1'b1;
    sdi       = 1'b0;
    slow_addr = '0;
    slow_dly  = 3;
    tick(5);
    chk("rst_sdo", sdo === 1'b0);
    chk("rst_sdo_oe", sdo_oe === 1'b0);
    chk("rst_uploading", uploading === 1'b0);
    chk("rst_mem_rd", mem_rd === 1'b0);
    chk("rst_mem_addr", mem_addr === 25'h0);
    chk("rst_underrun", underrun === 1'b0);
    chk("rst_crc", crc === CRC_RST);
    reset_n = 1'b1;
    tick(5);
    chk("rst_state", dut.state_q === S_IDLE);

    base = log_n;
    start_tx(32'h0000_1234);
    chk("basic_uploading", uploading === 1'b1);
    chk("basic_sdo_oe", sdo_oe === 1'b1);
    get_bytes(4, 1'b0);
    end_tx();
    chk("basic_b0", rxb[0] === 8'h34);
    chk("basic_b1", rxb[1] === 8'h35);
    chk("basic_b2", rxb[2] === 8'h36);
    chk("basic_b3", rxb[3] === 8'h37);
    chk("basic_a0", req(base) === 25'h1234);
    chk("basic_a1", req(base + 1) === 25'h1235);
    chk("basic_a2", req(base + 2) === 25'h1236);
    chk("basic_a3", req(base + 3) === 25'h1237);
    chk("basic_underrun", underrun === 1'b0);
    chk("basic_end_upl", uploading === 1'b0);
    chk("basic_end_oe", sdo_oe === 1'b0);

    rd_base = rd_cnt;
    ss = 1'b0;
    #HALF;
    spi_byte(8'hA5, d, 1'b0);
    chk("badcmd_state", dut.state_q === S_IGNORE);
    for (int k = 0; k < 5; k++) spi_byte(8'h57, d, 1'b0);
    chk("badcmd_state2", dut.state_q === S_IGNORE);
    chk("badcmd_oe", sdo_oe === 1'b0);
    chk("badcmd_upl", uploading === 1'b0);
    end_tx();
    chk("badcmd_no_rd", rd_cnt === rd_base);

    slow_addr = 25'h1235;
    slow_dly  = 100;
    base = log_n;
    start_tx(32'h0000_1234);
    get_bytes(4, 1'b0);
    end_tx();
    slow_dly = 3;
    chk("ur_b0", rxb[0] === 8'h34);
    chk("ur_b1", rxb[1] === 8'hFF);
    chk("ur_b2", rxb[2] === 8'h36);
    chk("ur_b3", rxb[3] === 8'h37);
    chk("ur_flag", underrun === 1'b1);
    chk("ur_a1", req(base + 1) === 25'h1235);
    chk("ur_a2", req(base + 2) === 25'h1236);

    base = log_n;
    start_tx(32'hFFFF_FFFF);
    get_bytes(2, 1'b0);
    end_tx();
    chk("wrap_a0", req(base) === 25'h1FFFFFF);
    chk("wrap_a1", req(base + 1) === 25'h0000000);
    chk("wrap_b0", rxb[0] === 8'hFF);
    chk("wrap_b1", rxb[1] === 8'h00);
    chk("wrap_underrun", underrun === 1'b0);

    slow_addr = 25'h1235;
    slow_dly  = 18;
    base = log_n;
    start_tx(32'h0000_1234);
    #HALF;
    ss = 1'b1;
    tick(4);
    chk("abort_rd_held", mem_rd === 1'b1);
    chk("abort_upl", uploading === 1'b0);
    chk("abort_oe", sdo_oe === 1'b0);
    start_tx(32'h0000_0100);
    get_bytes(2, 1'b0);
    end_tx();
    slow_dly = 3;
    chk("abort_b0", rxb[0] === 8'h00);
    chk("abort_b1", rxb[1] === 8'h01);
    chk("abort_a2", req(base + 2) === 25'h0100);
    chk("abort_underrun", underrun === 1'b0);

    slow_addr = 25'h0202;
    slow_dly  = 50;
    start_tx(32'h0000_0200);
    get_bytes(1, 1'b0);
    tick(10);
    chk("mid_pre_rd", mem_rd === 1'b1);
    chk("mid_pre_addr", mem_addr === 25'h0202);
    chk("mid_pre_oe", sdo_oe === 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_sdo", sdo === 1'b0);
    chk("mid_oe", sdo_oe === 1'b0);
    chk("mid_upl", uploading === 1'b0);
    chk("mid_rd", mem_rd === 1'b0);
    chk("mid_addr", mem_addr === 25'h0);
    chk("mid_underrun", underrun === 1'b0);
    chk("mid_crc", crc === CRC_RST);
    ss  = 1'b1;
    sck = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    slow_dly = 3;

    start_tx(32'h0000_0031);
    get_bytes(9, 1'b1);
    end_tx();
    chk("crc_b0", rxb[0] === 8'h31);
    chk("crc_b8", rxb[8] === 8'h39);
    chk("crc_underrun", underrun === 1'b0);
    chk("crc_value", crc === CRC_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
